// File: rtl/sram_axi_bridge_if.sv
// Bundles the sram-like inst/data request channels and the AXI master channels.
// Latency: wiring only, no storage.
// Backpressure: carried by addr_ok/data_ok on the sram side and valid/ready on AXI.
interface sram_axi_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  // instruction fetch channel (read-only)
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;

  // data access channel (read/write)
  logic              data_req;
  logic              data_wr;
  logic [STRB_W-1:0] data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [DATA_W-1:0] data_rdata;

  // AXI read channels
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              rready;

  // AXI write channels
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic              bvalid;
  logic              bready;

  // bridge side: serves the CPU requests, masters the AXI port
  modport slave (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output araddr, arvalid, rready,
    input  arready, rdata, rvalid,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bvalid
  );

  // environment side: CPU pipeline plus system interconnect
  modport master (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  araddr, arvalid, rready,
    output arready, rdata, rvalid,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bvalid
  );
endinterface

// File: rtl/sram_axi_bridge.sv
// Merges inst-fetch reads and data reads/writes onto one AXI master, one read + one write in flight.
// Latency: addr_ok in the request cycle, arvalid/awvalid+wvalid next cycle, data_ok on the rvalid/bvalid cycle.
// Backpressure: addr_ok withheld while the channel is busy or a hazard exists; AXI valids held until ready.
module sram_axi_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              resetn,
  sram_axi_bridge_if.slave bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF    = $clog2(STRB_W);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_AR   = 2'd1;
  localparam logic [1:0] R_R    = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_REQ  = 2'd1;
  localparam logic [1:0] W_B    = 2'd2;

  logic [1:0]        r_state;
  logic              r_owner_data;
  logic [ADDR_W-1:0] araddr_q;

  logic [1:0]        w_state;
  logic [ADDR_W-1:0] awaddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic              aw_done;
  logic              w_done;

  logic data_rd_req;
  logic data_wr_req;
  logic wr_hazard;
  logic grant_data_rd;
  logic grant_inst;
  logic accept_wr;
  logic rd_done;
  logic wr_done;
  logic awvalid_int;
  logic wvalid_int;
  logic aw_done_nxt;
  logic w_done_nxt;

  // Arbitration: data read beats inst read; data reads and writes are mutually exclusive
  always_comb begin
    data_rd_req   = bus.data_req & ~bus.data_wr;
    data_wr_req   = bus.data_req &  bus.data_wr;
    // word-granular compare so a fetch never overtakes a pending store to the same word
    wr_hazard     = (w_state != W_IDLE) &&
                    (bus.inst_addr[ADDR_W-1:OFF] == awaddr_q[ADDR_W-1:OFF]);
    grant_data_rd = (r_state == R_IDLE) && data_rd_req && (w_state == W_IDLE);
    grant_inst    = (r_state == R_IDLE) && bus.inst_req && !grant_data_rd && !wr_hazard;
    accept_wr     = (w_state == W_IDLE) && data_wr_req &&
                    !((r_state != R_IDLE) && r_owner_data);
    rd_done       = (r_state == R_R) && bus.rvalid;
    wr_done       = (w_state == W_B) && bus.bvalid;
    awvalid_int   = (w_state == W_REQ) && !aw_done;
    wvalid_int    = (w_state == W_REQ) && !w_done;
    aw_done_nxt   = aw_done | (awvalid_int & bus.awready);
    w_done_nxt    = w_done  | (wvalid_int  & bus.wready);
  end

  // Read FSM: latch owner/address on grant, present AR, then wait for the single R beat
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= R_IDLE;
      r_owner_data <= 1'b0;
      araddr_q     <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (grant_data_rd) begin
            r_state      <= R_AR;
            r_owner_data <= 1'b1;
            araddr_q     <= bus.data_addr;
          end else if (grant_inst) begin
            r_state      <= R_AR;
            r_owner_data <= 1'b0;
            araddr_q     <= bus.inst_addr;
          end
        end
        R_AR:    if (bus.arready) r_state <= R_R;
        R_R:     if (bus.rvalid)  r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // Write FSM: AW and W handshake independently, then wait for the B response
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state  <= W_IDLE;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (accept_wr) begin
            w_state  <= W_REQ;
            awaddr_q <= bus.data_addr;
            wdata_q  <= bus.data_wdata;
            wstrb_q  <= bus.data_wstrb;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
          end
        end
        W_REQ: begin
          if (aw_done_nxt && w_done_nxt) begin
            w_state <= W_B;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end else begin
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
          end
        end
        W_B:     if (bus.bvalid) w_state <= W_IDLE;
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // sram side: accept strobes are masked during reset so nothing is acknowledged while held
  assign bus.inst_addr_ok = resetn & grant_inst;
  assign bus.data_addr_ok = resetn & (grant_data_rd | accept_wr);
  assign bus.inst_data_ok = rd_done & ~r_owner_data;
  assign bus.data_data_ok = (rd_done & r_owner_data) | wr_done;
  assign bus.inst_rdata   = bus.rdata;
  assign bus.data_rdata   = bus.rdata;

  // AXI side
  assign bus.araddr  = araddr_q;
  assign bus.arvalid = (r_state == R_AR);
  assign bus.rready  = (r_state == R_R);
  assign bus.awaddr  = awaddr_q;
  assign bus.awvalid = awvalid_int;
  assign bus.wdata   = wdata_q;
  assign bus.wstrb   = wstrb_q;
  assign bus.wvalid  = wvalid_int;
  assign bus.bready  = (w_state == W_B);
endmodule

// File: tb/tb_sram_axi_bridge.sv
module tb_sram_axi_bridge;
  logic clk;
  logic resetn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_axi_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  sram_axi_bridge_if #(.ADDR_W(32), .DATA_W(64)) bus64 ();

  sram_axi_bridge #(.ADDR_W(32), .DATA_W(32)) dut   (.clk(clk), .resetn(resetn), .bus(bus));
  sram_axi_bridge #(.ADDR_W(32), .DATA_W(64)) dut64 (.clk(clk), .resetn(resetn), .bus(bus64));

  int checks;
  int failures;

  typedef struct {
    logic        is_wr;
    logic [31:0] rdata;
  } exp_t;

  exp_t        data_q[$];
  logic [31:0] inst_q[$];
  exp_t        mon_d;
  logic [31:0] mon_i;

  // kind: 0 inst read, 1 data read, 2 data write
  // reads: d_a = arready delay, d_r = rvalid delay; writes: d_a/d_w = awready/wready delay, d_r = bvalid delay
  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          d_a;
    int          d_w;
    int          d_r;
    logic [31:0] resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.inst_req = 0;  bus.inst_addr = 0;
    bus.data_req = 0;  bus.data_wr = 0;  bus.data_wstrb = 0;
    bus.data_addr = 0; bus.data_wdata = 0;
    bus.arready = 0;   bus.rdata = 0;    bus.rvalid = 0;
    bus.awready = 0;   bus.wready = 0;   bus.bvalid = 0;
    bus64.inst_req = 0;  bus64.inst_addr = 0;
    bus64.data_req = 0;  bus64.data_wr = 0;  bus64.data_wstrb = 0;
    bus64.data_addr = 0; bus64.data_wdata = 0;
    bus64.arready = 0;   bus64.rdata = 0;    bus64.rvalid = 0;
    bus64.awready = 0;   bus64.wready = 0;   bus64.bvalid = 0;
  endtask

  // Scoreboard: every completion pops the oldest expectation of its channel
  always @(negedge clk) begin
    if (bus.inst_data_ok) begin
      if (inst_q.size() == 0) chk1("inst_unexpected_data_ok", 1'b1, 1'b0);
      else begin
        mon_i = inst_q.pop_front();
        chk32("inst_rdata", bus.inst_rdata, mon_i);
      end
    end
    if (bus.data_data_ok) begin
      if (data_q.size() == 0) chk1("data_unexpected_data_ok", 1'b1, 1'b0);
      else begin
        mon_d = data_q.pop_front();
        chk1("data_ok_kind_is_write", bus.bvalid & bus.bready, mon_d.is_wr);
        if (!mon_d.is_wr) chk32("data_rdata", bus.data_rdata, mon_d.rdata);
      end
    end
  end

  // Isolated read: request, AR with delay, R with delay; checks cycle-level handshakes
  task automatic rd_txn(input bit is_data, input logic [31:0] addr, input int ar_dly,
                        input int r_dly, input logic [31:0] resp, input logic [31:0] exp_rd);
    int  n;
    bit  granted;
    exp_t e;
    if (is_data) begin
      bus.data_req = 1; bus.data_wr = 0; bus.data_addr = addr;
    end else begin
      bus.inst_req = 1; bus.inst_addr = addr;
    end
    granted = 0;
    n = 0;
    while (!granted && n < 20) begin
      @(negedge clk);
      if (is_data ? bus.data_addr_ok : bus.inst_addr_ok) granted = 1;
      else begin nxt(); n++; end
    end
    chk1("rd_granted", granted, 1'b1);
    chk32("rd_addr_ok_latency", n, 0);
    if (!granted) begin
      idle_inputs();
      return;
    end
    if (is_data) begin
      e.is_wr = 0; e.rdata = exp_rd; data_q.push_back(e);
    end else inst_q.push_back(exp_rd);
    nxt();
    bus.inst_req = 0; bus.data_req = 0;
    for (int k = 0; k <= ar_dly; k++) begin
      bus.arready = (k == ar_dly);
      @(negedge clk);
      chk1("arvalid_held", bus.arvalid, 1'b1);
      chk32("araddr", bus.araddr, addr);
      nxt();
    end
    bus.arready = 0;
    for (int k = 0; k <= r_dly; k++) begin
      bus.rvalid = (k == r_dly);
      bus.rdata  = (k == r_dly) ? resp : 32'hdeadbeef;
      @(negedge clk);
      chk1("rready", bus.rready, 1'b1);
      chk1("arvalid_dropped", bus.arvalid, 1'b0);
      chk1("inst_data_ok_timing", bus.inst_data_ok, (k == r_dly) && !is_data);
      chk1("data_data_ok_timing", bus.data_data_ok, (k == r_dly) && is_data);
      nxt();
    end
    bus.rvalid = 0;
    @(negedge clk);
    chk1("rready_after_done", bus.rready, 1'b0);
    nxt();
  endtask

  // Isolated write with independent AW/W ready delays and a delayed B response
  task automatic wr_txn(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] ws,
                        input int aw_dly, input int w_dly, input int b_dly);
    int  i;
    bit  aw_hs;
    bit  w_hs;
    bit  awr;
    bit  wr;
    exp_t e;
    bus.data_req = 1; bus.data_wr = 1; bus.data_addr = addr;
    bus.data_wdata = wd; bus.data_wstrb = ws;
    @(negedge clk);
    chk1("wr_addr_ok", bus.data_addr_ok, 1'b1);
    if (!bus.data_addr_ok) begin
      idle_inputs();
      nxt();
      return;
    end
    e.is_wr = 1; e.rdata = 0; data_q.push_back(e);
    nxt();
    bus.data_req = 0; bus.data_wr = 0;
    i = 0; aw_hs = 0; w_hs = 0;
    while (!(aw_hs && w_hs) && i < 40) begin
      awr = !aw_hs && (i >= aw_dly);
      wr  = !w_hs  && (i >= w_dly);
      bus.awready = awr;
      bus.wready  = wr;
      @(negedge clk);
      chk1("awvalid", bus.awvalid, !aw_hs);
      chk1("wvalid", bus.wvalid, !w_hs);
      if (!aw_hs) chk32("awaddr", bus.awaddr, addr);
      if (!w_hs) begin
        chk32("wdata", bus.wdata, wd);
        chk32("wstrb", {28'b0, bus.wstrb}, {28'b0, ws});
      end
      nxt();
      if (awr) aw_hs = 1;
      if (wr)  w_hs  = 1;
      i++;
    end
    bus.awready = 0; bus.wready = 0;
    chk1("wr_req_done_in_budget", aw_hs && w_hs, 1'b1);
    for (int k = 0; k <= b_dly; k++) begin
      bus.bvalid = (k == b_dly);
      @(negedge clk);
      chk1("bready", bus.bready, 1'b1);
      chk1("wr_data_ok_timing", bus.data_data_ok, (k == b_dly));
      nxt();
    end
    bus.bvalid = 0;
    @(negedge clk);
    chk1("bready_after_done", bus.bready, 1'b0);
    nxt();
  endtask

  // AR then R with no delays, after the caller has dropped the request
  task automatic serve_read(input logic [31:0] addr, input logic [31:0] resp);
    bus.arready = 1;
    @(negedge clk);
    chk1("serve_arvalid", bus.arvalid, 1'b1);
    chk32("serve_araddr", bus.araddr, addr);
    nxt();
    bus.arready = 0; bus.rvalid = 1; bus.rdata = resp;
    @(negedge clk);
    chk1("serve_rready", bus.rready, 1'b1);
    nxt();
    bus.rvalid = 0;
  endtask

  // Accept a write and complete AW/W at once, leaving the FSM waiting for B
  task automatic start_write(input logic [31:0] addr);
    exp_t e;
    bus.data_req = 1; bus.data_wr = 1; bus.data_addr = addr;
    bus.data_wdata = 32'h5a5a5a5a; bus.data_wstrb = 4'hf;
    @(negedge clk);
    chk1("sw_addr_ok", bus.data_addr_ok, 1'b1);
    e.is_wr = 1; e.rdata = 0; data_q.push_back(e);
    nxt();
    bus.data_req = 0; bus.data_wr = 0;
    bus.awready = 1; bus.wready = 1;
    @(negedge clk);
    chk1("sw_aw_w_valid", bus.awvalid & bus.wvalid, 1'b1);
    nxt();
    bus.awready = 0; bus.wready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout t=%0t", $time);
    $fatal(1, "bench did not finish in time");
  end

  initial begin
    exp_t e;
    checks = 0;
    failures = 0;
    idle_inputs();
    resetn = 0;

    vecs[0] = '{0, 32'h1c000000, 32'h0,        4'h0, 0, 0, 0, 32'h02800c0c, 32'h02800c0c};
    vecs[1] = '{1, 32'h00001000, 32'h0,        4'h0, 1, 0, 2, 32'h00000011, 32'h00000011};
    vecs[2] = '{2, 32'h00002004, 32'h00AB0000, 4'h4, 3, 0, 0, 32'h0,        32'h0};
    vecs[3] = '{2, 32'h00002008, 32'hcafef00d, 4'hf, 0, 2, 1, 32'h0,        32'h0};
    vecs[4] = '{0, 32'h1c000004, 32'h0,        4'h0, 2, 0, 3, 32'h12345678, 32'h12345678};
    vecs[5] = '{1, 32'h80000000, 32'h0,        4'h0, 1, 0, 0, 32'hffffffff, 32'hffffffff};

    // reset state, with a request pending to confirm nothing is acknowledged
    bus.inst_req = 1; bus.inst_addr = 32'h1c000000;
    @(negedge clk);
    @(negedge clk);
    chk32("reset_ctrl_outputs", 32'({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready,
          bus.inst_addr_ok, bus.data_addr_ok, bus.inst_data_ok, bus.data_data_ok}), 0);
    chk32("reset_araddr", bus.araddr, 0);
    chk32("reset_awaddr", bus.awaddr, 0);
    chk32("reset_wdata", bus.wdata, 0);
    bus.inst_req = 0;
    nxt();
    resetn = 1;
    nxt();

    // table-driven isolated transactions
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].kind == 2)
        wr_txn(vecs[v].addr, vecs[v].wdata, vecs[v].wstrb, vecs[v].d_a, vecs[v].d_w, vecs[v].d_r);
      else
        rd_txn(vecs[v].kind == 1, vecs[v].addr, vecs[v].d_a, vecs[v].d_r, vecs[v].resp, vecs[v].exp_rdata);
    end

    // inst and data read in the same cycle: data first, inst only after return to idle
    bus.inst_req = 1; bus.inst_addr = 32'h1c000010;
    bus.data_req = 1; bus.data_wr = 0; bus.data_addr = 32'h1000;
    @(negedge clk);
    chk1("both_data_granted", bus.data_addr_ok, 1'b1);
    chk1("both_inst_held", bus.inst_addr_ok, 1'b0);
    e.is_wr = 0; e.rdata = 32'h11; data_q.push_back(e);
    nxt();
    bus.data_req = 0; bus.arready = 1;
    @(negedge clk);
    chk1("both_inst_held_ar", bus.inst_addr_ok, 1'b0);
    chk32("both_araddr_data", bus.araddr, 32'h1000);
    nxt();
    bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'h11;
    @(negedge clk);
    chk1("both_inst_held_completion", bus.inst_addr_ok, 1'b0);
    chk1("both_data_ok", bus.data_data_ok, 1'b1);
    nxt();
    bus.rvalid = 0;
    @(negedge clk);
    chk1("both_inst_granted_later", bus.inst_addr_ok, 1'b1);
    inst_q.push_back(32'h22);
    nxt();
    bus.inst_req = 0;
    serve_read(32'h1c000010, 32'h22);

    // write-address hazard blocks the fetch until B completes
    start_write(32'h3000);
    bus.inst_req = 1; bus.inst_addr = 32'h3000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("hazard_inst_blocked", bus.inst_addr_ok, 1'b0);
      chk1("hazard_bready", bus.bready, 1'b1);
      nxt();
    end
    bus.bvalid = 1;
    @(negedge clk);
    chk1("hazard_b_cycle_blocked", bus.inst_addr_ok, 1'b0);
    chk1("hazard_write_ok", bus.data_data_ok, 1'b1);
    nxt();
    bus.bvalid = 0;
    @(negedge clk);
    chk1("hazard_released", bus.inst_addr_ok, 1'b1);
    inst_q.push_back(32'h30);
    nxt();
    bus.inst_req = 0;
    serve_read(32'h3000, 32'h30);

    // different word: no hazard, fetch granted while the write waits for B
    start_write(32'h3000);
    bus.inst_req = 1; bus.inst_addr = 32'h3008;
    @(negedge clk);
    chk1("nohazard_inst_granted", bus.inst_addr_ok, 1'b1);
    inst_q.push_back(32'h38);
    nxt();
    bus.inst_req = 0;
    serve_read(32'h3008, 32'h38);
    bus.bvalid = 1;
    @(negedge clk);
    chk1("nohazard_write_ok", bus.data_data_ok, 1'b1);
    nxt();
    bus.bvalid = 0;

    // data read held off by an outstanding data write
    bus.data_req = 1; bus.data_wr = 1; bus.data_addr = 32'h5000;
    bus.data_wdata = 32'h1; bus.data_wstrb = 4'h1;
    @(negedge clk);
    chk1("wr_then_rd_wr_ok", bus.data_addr_ok, 1'b1);
    e.is_wr = 1; e.rdata = 0; data_q.push_back(e);
    nxt();
    bus.data_wr = 0; bus.data_addr = 32'h4000;
    @(negedge clk);
    chk1("rd_blocked_wreq", bus.data_addr_ok, 1'b0);
    nxt();
    bus.awready = 1; bus.wready = 1;
    @(negedge clk);
    chk1("rd_blocked_wreq_hs", bus.data_addr_ok, 1'b0);
    nxt();
    bus.awready = 0; bus.wready = 0;
    @(negedge clk);
    chk1("rd_blocked_wb", bus.data_addr_ok, 1'b0);
    nxt();
    bus.bvalid = 1;
    @(negedge clk);
    chk1("rd_blocked_b_cycle", bus.data_addr_ok, 1'b0);
    nxt();
    bus.bvalid = 0;
    @(negedge clk);
    chk1("rd_granted_after_write", bus.data_addr_ok, 1'b1);
    e.is_wr = 0; e.rdata = 32'h44; data_q.push_back(e);
    nxt();
    bus.data_req = 0;
    serve_read(32'h4000, 32'h44);

    // data write held off by an outstanding data read
    bus.data_req = 1; bus.data_wr = 0; bus.data_addr = 32'h4100;
    @(negedge clk);
    chk1("rd_then_wr_rd_ok", bus.data_addr_ok, 1'b1);
    e.is_wr = 0; e.rdata = 32'h55; data_q.push_back(e);
    nxt();
    bus.data_wr = 1; bus.data_addr = 32'h4200; bus.data_wdata = 32'h2; bus.data_wstrb = 4'h2;
    bus.arready = 1;
    @(negedge clk);
    chk1("wr_blocked_ar", bus.data_addr_ok, 1'b0);
    nxt();
    bus.arready = 0;
    @(negedge clk);
    chk1("wr_blocked_r", bus.data_addr_ok, 1'b0);
    nxt();
    bus.rvalid = 1; bus.rdata = 32'h55;
    @(negedge clk);
    chk1("wr_blocked_r_cycle", bus.data_addr_ok, 1'b0);
    nxt();
    bus.rvalid = 0;
    @(negedge clk);
    chk1("wr_granted_after_read", bus.data_addr_ok, 1'b1);
    e.is_wr = 1; e.rdata = 0; data_q.push_back(e);
    nxt();
    bus.data_req = 0; bus.data_wr = 0;
    bus.awready = 1; bus.wready = 1;
    nxt();
    bus.awready = 0; bus.wready = 0; bus.bvalid = 1;
    @(negedge clk);
    chk1("wr_after_read_b_ok", bus.data_data_ok, 1'b1);
    nxt();
    bus.bvalid = 0;

    // reset while waiting for R: everything drops at once, the late beat is ignored
    bus.data_req = 1; bus.data_wr = 0; bus.data_addr = 32'h6000;
    @(negedge clk);
    chk1("rst_seq_rd_ok", bus.data_addr_ok, 1'b1);
    e.is_wr = 0; e.rdata = 32'h66; data_q.push_back(e);
    nxt();
    bus.data_req = 0; bus.arready = 1;
    nxt();
    bus.arready = 0;
    @(negedge clk);
    chk1("rst_seq_in_r", bus.rready, 1'b1);
    nxt();
    resetn = 0;
    bus.inst_req = 1; bus.inst_addr = 32'h1c000000;
    bus.data_req = 1; bus.data_wr = 1; bus.data_addr = 32'h7000;
    data_q.delete();
    inst_q.delete();
    #1;
    chk32("rst_async_outputs", 32'({bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready,
          bus.inst_addr_ok, bus.data_addr_ok, bus.inst_data_ok, bus.data_data_ok}), 0);
    nxt();
    bus.rvalid = 1; bus.rdata = 32'hbad0bad0;
    bus.inst_req = 0; bus.data_req = 0; bus.data_wr = 0;
    @(negedge clk);
    chk1("rst_late_rvalid_no_ok", bus.data_data_ok | bus.inst_data_ok, 1'b0);
    chk32("rst_araddr_cleared", bus.araddr, 0);
    nxt();
    resetn = 1;
    @(negedge clk);
    chk1("post_rst_rvalid_ignored", bus.data_data_ok | bus.inst_data_ok | bus.rready, 1'b0);
    nxt();
    bus.rvalid = 0;
    @(negedge clk);
    chk1("post_rst_still_idle", bus.rready | bus.arvalid, 1'b0);
    nxt();
    rd_txn(1'b1, 32'h6004, 0, 0, 32'h6004abcd, 32'h6004abcd);

    // 64-bit data path, minimum-latency fetch
    bus64.inst_req = 1; bus64.inst_addr = 32'h1c000000;
    @(negedge clk);
    chk1("w64_inst_addr_ok", bus64.inst_addr_ok, 1'b1);
    nxt();
    bus64.inst_req = 0; bus64.arready = 1;
    @(negedge clk);
    chk1("w64_arvalid", bus64.arvalid, 1'b1);
    chk32("w64_araddr", bus64.araddr, 32'h1c000000);
    nxt();
    bus64.arready = 0; bus64.rvalid = 1; bus64.rdata = 64'h89abcdef_02800c0c;
    @(negedge clk);
    chk1("w64_arvalid_one_cycle", bus64.arvalid, 1'b0);
    chk1("w64_inst_data_ok", bus64.inst_data_ok, 1'b1);
    chk32("w64_rdata_lo", bus64.inst_rdata[31:0], 32'h02800c0c);
    chk32("w64_rdata_hi", bus64.inst_rdata[63:32], 32'h89abcdef);
    chk1("w64_data_data_ok_quiet", bus64.data_data_ok, 1'b0);
    nxt();
    bus64.rvalid = 0;
    @(negedge clk);
    chk1("w64_done", bus64.inst_data_ok | bus64.rready, 1'b0);
    nxt();

    chk32("sb_inst_drained", inst_q.size(), 0);
    chk32("sb_data_drained", data_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
